snn_timestep_scheduler: RTL and testbench

Sequences inference runs of the spiking network core. Issues one input_ready pulse per timestep, waits for the core's data_valid_out, and accumulates per-neuron output spike counts over a programmed number of timesteps. Sits between the host-facing pad logic and spiking_network_top. Replaces manual toggling of input_ready from a pin.

---
 rtl/snn_sched_pkg.sv | 21 ++
 rtl/snn_spike_accumulator.sv | 25 ++
 rtl/snn_timestep_scheduler.sv | 109 ++++++++++
 tb/tb_snn_timestep_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_sched_pkg.sv
// snn_sched_pkg: state encoding, default widths and saturating increment shared by the timestep scheduler
package snn_sched_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ISSUE      = 3'd1,
      WAIT_VALID = 3'd2,
      GAP        = 3'd3,
      DONE       = 3'd4
   } state_t;

   localparam int DEF_NUM_OUT   = 2;
   localparam int DEF_CNT_W     = 8;
   localparam int DEF_GAP_W     = 8;
   localparam int DEF_TIMEOUT_W = 12;

   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max, input logic inc);
      return (inc && value != max) ? value + 32'd1 : value;
   endfunction

endpackage

// File: rtl/snn_spike_accumulator.sv
// snn_spike_accumulator: NUM_OUT saturating per-neuron spike counters with clear and enable
module snn_spike_accumulator
   import snn_sched_pkg::*;
#(
   parameter int NUM_OUT = DEF_NUM_OUT,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                     system_clock,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     enable,
   input  logic [NUM_OUT-1:0]       spikes,
   output logic [NUM_OUT*CNT_W-1:0] spike_count
);

   localparam logic [31:0] MAX = 32'({CNT_W{1'b1}});

   // Each counter clears on reset or a new run, otherwise adds its spike bit and pins at all-ones
   always_ff @(posedge system_clock) begin
      for (int i = 0; i < NUM_OUT; i++)
         spike_count[i*CNT_W +: CNT_W] <= (reset || clear) ? '0 :
            CNT_W'(sat_inc(32'(spike_count[i*CNT_W +: CNT_W]), MAX, enable && spikes[i]));
   end

endmodule

// File: rtl/snn_timestep_scheduler.sv
// snn_timestep_scheduler: issues one input_ready per timestep, waits for the core result and accumulates spike counts
// Optional watchdog on WAIT_VALID enabled by defining SNN_SCHED_TIMEOUT_EN.
module snn_timestep_scheduler
   import snn_sched_pkg::*;
#(
   parameter int NUM_OUT   = DEF_NUM_OUT,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int GAP_W     = DEF_GAP_W,
   parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
   input  logic                     system_clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic [CNT_W-1:0]         num_steps,
   input  logic [GAP_W-1:0]         gap_cycles,
   input  logic                     spi_busy,
   input  logic                     data_valid_out,
   input  logic [NUM_OUT-1:0]       output_spikes,
   output logic                     input_ready,
   output logic                     busy,
   output logic                     done,
   output logic [NUM_OUT*CNT_W-1:0] spike_count,
   output logic [CNT_W-1:0]         steps_done,
   output logic                     timeout_err
);

   state_t           state, next;
   logic [CNT_W-1:0] steps_q;
   logic [GAP_W-1:0] gap_q, gap_cnt;
   logic             launch, take, last, timeout_hit;

   assign launch = (state == IDLE || state == DONE) && start && !abort;
   assign take   = state == WAIT_VALID && data_valid_out && !abort;
   assign last   = steps_done + CNT_W'(1) == steps_q;
   assign busy   = state == ISSUE || state == WAIT_VALID || state == GAP;
   assign done   = state == DONE;

   // Next-state selection; abort overrides everything else
   always_comb begin
      next = state;
      case (state)
         IDLE, DONE: next = start ? ISSUE : state;
         ISSUE:      next = spi_busy ? ISSUE : WAIT_VALID;
         WAIT_VALID: next = data_valid_out ? (last ? DONE : (gap_q == '0 ? ISSUE : GAP)) :
                            (timeout_hit ? DONE : WAIT_VALID);
         GAP:        next = gap_cnt <= GAP_W'(1) ? ISSUE : GAP;
         default:    next = IDLE;
      endcase
      if (abort) next = IDLE;
   end

   // State register
   always_ff @(posedge system_clock) state <= reset ? IDLE : next;

   // Run parameters, step counter, gap countdown and the registered input_ready pulse
   always_ff @(posedge system_clock) begin
      if (reset) begin
         input_ready <= 1'b0;
         steps_q     <= '0;
         gap_q       <= '0;
         gap_cnt     <= '0;
         steps_done  <= '0;
      end else begin
         input_ready <= state == ISSUE && next == WAIT_VALID;
         if (launch) begin
            steps_q <= num_steps == '0 ? CNT_W'(1) : num_steps;
            gap_q   <= gap_cycles;
         end
         steps_done <= launch ? '0 : (take ? steps_done + CNT_W'(1) : steps_done);
         gap_cnt    <= take ? gap_q : (state == GAP ? gap_cnt - GAP_W'(1) : gap_cnt);
      end
   end

   snn_spike_accumulator #(
      .NUM_OUT(NUM_OUT),
      .CNT_W  (CNT_W)
   ) u_acc (
      .system_clock(system_clock),
      .reset       (reset),
      .clear       (launch),
      .enable      (take),
      .spikes      (output_spikes),
      .spike_count (spike_count)
   );

`ifdef SNN_SCHED_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] wd;

   assign timeout_hit = state == WAIT_VALID && &wd && !data_valid_out && !abort;

   // Watchdog runs only while waiting on the core; the error flag sticks until the next run starts
   always_ff @(posedge system_clock) begin
      if (reset) begin
         wd          <= '0;
         timeout_err <= 1'b0;
      end else begin
         wd          <= state == WAIT_VALID ? wd + TIMEOUT_W'(1) : '0;
         timeout_err <= launch ? 1'b0 : (timeout_err | timeout_hit);
      end
   end
`else
   localparam int unused_timeout_w = TIMEOUT_W;

   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// tb_snn_timestep_scheduler: table vectors, random runs against a run-level model, and hand-written corner sequences
module tb_snn_timestep_scheduler;

   localparam int NUM_OUT   = 2;
   localparam int CNT_W     = 8;
   localparam int GAP_W     = 8;
   localparam int TIMEOUT_W = 4;

   logic             system_clock = 1'b0;
   logic             reset = 1'b1, start = 1'b0, abort = 1'b0, spi_busy = 1'b0;
   logic [CNT_W-1:0] num_steps = '0;
   logic [GAP_W-1:0] gap_cycles = '0;
   logic             core_dv = 1'b0, man_dv = 1'b0;
   logic [1:0]       core_spk = '0, man_spk = '0;
   logic             data_valid_out;
   logic [1:0]       output_spikes;
   logic             input_ready, busy, done, timeout_err;
   logic [15:0]      spike_count;
   logic [7:0]       steps_done;

   assign data_valid_out = core_dv | man_dv;
   assign output_spikes  = core_dv ? core_spk : man_spk;

   int         cyc = 0;
   int         n_chk = 0, n_pass = 0;
   int         core_lat = 4;
   bit         core_on = 1'b0;
   int         spk_mode = 0;
   logic [5:0] spk_tab = '0;
   int         base = 0;
   logic [1:0] sent[$];
   int         ir_t[$];
   int         dv_t[$];

   typedef struct {
      int         ns;
      int         gap;
      int         lat;
      logic [5:0] spk;
      bit         poke;
      logic [15:0] exp_cnt;
      int         exp_steps;
   } vec_t;

   vec_t tab[4];

   snn_timestep_scheduler #(
      .NUM_OUT  (NUM_OUT),
      .CNT_W    (CNT_W),
      .GAP_W    (GAP_W),
      .TIMEOUT_W(TIMEOUT_W)
   ) dut (
      .system_clock  (system_clock),
      .reset         (reset),
      .start         (start),
      .abort         (abort),
      .num_steps     (num_steps),
      .gap_cycles    (gap_cycles),
      .spi_busy      (spi_busy),
      .data_valid_out(data_valid_out),
      .output_spikes (output_spikes),
      .input_ready   (input_ready),
      .busy          (busy),
      .done          (done),
      .spike_count   (spike_count),
      .steps_done    (steps_done),
      .timeout_err   (timeout_err)
   );

   always #5 system_clock = ~system_clock;

   always @(posedge system_clock) cyc <= cyc + 1;

   always @(negedge system_clock) begin
      if (input_ready) ir_t.push_back(cyc);
      if (data_valid_out) dv_t.push_back(cyc);
   end

   // Core model: answers each input_ready with one data_valid_out core_lat cycles later
   initial forever begin
      @(posedge system_clock);
      #1;
      if (input_ready && core_on) begin
         int k;
         repeat (core_lat) begin
            @(posedge system_clock);
            #1;
         end
         k = sent.size() - base;
         core_spk = spk_mode == 1 ? 2'b11 :
                    (spk_mode == 2 && k < 3) ? spk_tab[2*k +: 2] : 2'($urandom_range(0, 3));
         sent.push_back(core_spk);
         core_dv = 1'b1;
         @(posedge system_clock);
         #1;
         core_dv = 1'b0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge system_clock);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic run(input int ns, input int gap, input int lat, input bit poke, input string tag);
      int eff, bound, k, irb, dvb, bad, c0, c1;
      eff = ns == 0 ? 1 : ns;
      core_lat = lat;
      core_on = 1'b1;
      base = sent.size();
      irb = ir_t.size();
      dvb = dv_t.size();
      num_steps = 8'(ns);
      gap_cycles = 8'(gap);
      start = 1'b1;
      tick();
      start = 1'b0;
      bound = eff * (gap + lat + 4) + 20;
      k = 0;
      while (!done && k < bound) begin
         if (poke && k == 3) begin
            num_steps = 8'd1;
            start = 1'b1;
         end else start = 1'b0;
         tick();
         k++;
      end
      start = 1'b0;
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " steps_done"}, 32'(steps_done), 32'(eff));
      chk({tag, " input_ready_pulses"}, 32'(ir_t.size() - irb), 32'(eff));
      c0 = 0;
      c1 = 0;
      for (int i = base; i < sent.size(); i++) begin
         c0 += int'(sent[i][0]);
         c1 += int'(sent[i][1]);
      end
      c0 = c0 > 255 ? 255 : c0;
      c1 = c1 > 255 ? 255 : c1;
      chk({tag, " count0"}, 32'(spike_count[7:0]), 32'(c0));
      chk({tag, " count1"}, 32'(spike_count[15:8]), 32'(c1));
      bad = 0;
      for (int i = 0; i + 1 < ir_t.size() - irb && i < dv_t.size() - dvb; i++)
         if (ir_t[irb+i+1] - dv_t[dvb+i] != gap + 2) bad++;
      chk({tag, " spacing_errors"}, 32'(bad), 32'd0);
   endtask

   initial begin
      int k, n, irb, fall;
      tab[0] = '{3, 0, 4, 6'b10_11_01, 1'b1, 16'h0202, 3};
      tab[1] = '{2, 5, 3, 6'b00_00_11, 1'b0, 16'h0101, 2};
      tab[2] = '{0, 1, 2, 6'b00_00_10, 1'b0, 16'h0100, 1};
      tab[3] = '{1, 0, 1, 6'b00_00_11, 1'b0, 16'h0101, 1};

      tick(3);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      reset = 1'b0;
      tick();
      chk("post_reset input_ready", 32'(input_ready), 32'd0);
      chk("post_reset spike_count", 32'(spike_count), 32'd0);
      chk("post_reset steps_done", 32'(steps_done), 32'd0);
      chk("post_reset timeout_err", 32'(timeout_err), 32'd0);

      for (int i = 0; i < 4; i++) begin
         spk_mode = 2;
         spk_tab = tab[i].spk;
         run(tab[i].ns, tab[i].gap, tab[i].lat, tab[i].poke, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d table_count", i), 32'(spike_count), 32'(tab[i].exp_cnt));
         chk($sformatf("vec%0d table_steps", i), 32'(steps_done), 32'(tab[i].exp_steps));
      end

      spk_mode = 1;
      run(255, 0, 1, 1'b0, "max_run");
      chk("max_run counts", 32'(spike_count), 32'h0000_FFFF);
      chk("max_run steps", 32'(steps_done), 32'd255);

      spk_mode = 0;
      for (int i = 0; i < 8; i++)
         run(int'($urandom_range(1, 20)), int'($urandom_range(0, 6)), int'($urandom_range(1, 5)),
             1'b0, $sformatf("rnd%0d", i));

      // spi_busy held for ten cycles from the start pulse
      core_lat = 2;
      core_on = 1'b1;
      base = sent.size();
      irb = ir_t.size();
      num_steps = 8'd2;
      gap_cycles = 8'd0;
      start = 1'b1;
      spi_busy = 1'b1;
      tick();
      start = 1'b0;
      tick(9);
      fall = cyc;
      spi_busy = 1'b0;
      k = 0;
      while (!done && k < 40) begin
         tick();
         k++;
      end
      chk("spi done", 32'(done), 32'd1);
      chk("spi pulses", 32'(ir_t.size() - irb), 32'd2);
      chk("spi first_ready_cycle", 32'(ir_t.size() > irb ? ir_t[irb] : -1), 32'(fall + 1));

      // abort together with data_valid_out in WAIT_VALID
      core_on = 1'b0;
      tick(4);
      irb = ir_t.size();
      num_steps = 8'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (!input_ready && k < 20) begin
         tick();
         k++;
      end
      chk("abort first_ready", 32'(input_ready), 32'd1);
      man_dv = 1'b1;
      man_spk = 2'b01;
      tick();
      man_dv = 1'b0;
      k = 0;
      while (!input_ready && k < 20) begin
         tick();
         k++;
      end
      chk("abort second_ready", 32'(input_ready), 32'd1);
      man_dv = 1'b1;
      man_spk = 2'b11;
      abort = 1'b1;
      tick();
      man_dv = 1'b0;
      abort = 1'b0;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      chk("abort spike_count", 32'(spike_count), 32'h0000_0001);
      chk("abort steps_done", 32'(steps_done), 32'd1);
      n = ir_t.size();
      tick(10);
      chk("abort no_more_ready", 32'(ir_t.size() - n), 32'd0);
      chk("abort total_ready", 32'(ir_t.size() - irb), 32'd2);

      // a new start clears the counters left by the aborted run
      num_steps = 8'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart spike_count", 32'(spike_count), 32'd0);
      chk("restart steps_done", 32'(steps_done), 32'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;

      // reset in the middle of a run
      spk_mode = 0;
      core_lat = 3;
      core_on = 1'b1;
      num_steps = 8'd10;
      gap_cycles = 8'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(6);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midreset busy", 32'(busy), 32'd0);
      chk("midreset steps_done", 32'(steps_done), 32'd0);
      chk("midreset spike_count", 32'(spike_count), 32'd0);
      chk("midreset input_ready", 32'(input_ready), 32'd0);
      n = ir_t.size();
      tick(12);
      chk("midreset no_ready", 32'(ir_t.size() - n), 32'd0);

      // core never answers
      core_on = 1'b0;
      num_steps = 8'd1;
      gap_cycles = 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(25);
`ifdef SNN_SCHED_TIMEOUT_EN
      chk("silent_core timeout_err", 32'(timeout_err), 32'd1);
      chk("silent_core done", 32'(done), 32'd1);
      chk("silent_core busy", 32'(busy), 32'd0);
`else
      chk("silent_core timeout_err", 32'(timeout_err), 32'd0);
      chk("silent_core done", 32'(done), 32'd0);
      chk("silent_core busy", 32'(busy), 32'd1);
`endif
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("silent_core abort_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
